// File: rtl/minilab_pkg.sv
// Shared types and default sizes for the systolic loader.
// FSM state encoding plus helpers used by the loader and its skew generator.
package minilab_pkg;

  localparam int DEPTH_DEF  = 8;
  localparam int BITS_DEF   = 8;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_loader_skew_gen.sv
// Diagonal shift-enable generator for the transpose FIFOs.
// A start pulse launches counter c; FIFO i shifts while i <= c < i+DEPTH.
module skew_gen
  import minilab_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  output logic [DEPTH-1:0] o_shift_en,
  output logic             o_last
);

  localparam int C_W = min1_clog2(2 * DEPTH);
  localparam logic [C_W-1:0] C_LAST = C_W'(2 * DEPTH - 2);

  logic           r_active;
  logic [C_W-1:0] r_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_c      <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_c      <= '0;
    end else if (r_active) begin
      if (r_c == C_LAST) begin
        r_active <= 1'b0;
        r_c      <= '0;
      end else begin
        r_c <= r_c + 1'b1;
      end
    end
  end

  always_comb begin
    o_shift_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_shift_en[i] = r_active
                   && (int'(r_c) >= i)
                   && (int'(r_c) < i + DEPTH);
    end
  end

  assign o_last = r_active && (r_c == C_LAST);

endmodule

// File: rtl/systolic_loader.sv
// Loads a DEPTH x DEPTH matrix row by row into transpose FIFOs,
// then streams it out with a one-cycle-per-FIFO diagonal skew.
module systolic_loader
  import minilab_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int BITS   = BITS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DEPTH*BITS-1:0]   mem_rdata,
  input  logic                    mem_rvalid,
  output logic [DEPTH-1:0]        wr_en,
  output logic [DEPTH*BITS-1:0]   row_data,
  output logic [DEPTH-1:0]        shift_en,
  output logic                    busy,
  output logic                    done
);

  localparam int ROW_W = min1_clog2(DEPTH);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DEPTH - 1);
  localparam logic [DEPTH-1:0] ONE = DEPTH'(1);

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_W-1:0]       r_base;
  logic [ROW_W-1:0]        r_row;
  logic                    r_pend;
  logic [DEPTH*BITS-1:0]   r_row_data;
  logic [DEPTH-1:0]        r_wr_en;
  logic                    w_accept;
  logic                    w_skew_start;
  logic                    w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // r_pend marks the wr_en cycle that follows each accepted row
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_skew_start = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = READ;
      end
      READ: begin
        if (r_pend) begin
          if (r_row == LAST_ROW) begin
            w_next       = SHIFT;
            w_skew_start = 1'b1;
          end
        end else if (mem_rvalid) begin
          w_accept = 1'b1;
        end
      end
      SHIFT: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_row      <= '0;
      r_pend     <= 1'b0;
      r_row_data <= '0;
      r_wr_en    <= '0;
    end else begin
      r_wr_en <= '0;
      if (r_state == IDLE && start) begin
        r_base <= base_addr;
        r_row  <= '0;
        r_pend <= 1'b0;
      end
      if (w_accept) begin
        r_row_data <= mem_rdata;
        r_wr_en    <= ONE << r_row;
        r_pend     <= 1'b1;
      end
      if (r_state == READ && r_pend) begin
        r_pend <= 1'b0;
        if (r_row != LAST_ROW) r_row <= r_row + 1'b1;
      end
    end
  end

  skew_gen #(
    .DEPTH (DEPTH)
  ) u_skew (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_skew_start),
    .o_shift_en (shift_en),
    .o_last     (w_last)
  );

  assign mem_rd   = (r_state == READ) && !r_pend;
  assign mem_addr = mem_rd ? (r_base + ADDR_W'(r_row)) : '0;
  assign wr_en    = r_wr_en;
  assign row_data = r_row_data;
  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);

endmodule
